// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin owner of one 8:1 strobed mux.
// Drives select {c,b,a} and active-low strobe g with break-before-make.
//
// Ports:
//   clk, rst      clock (rising edge), async active-high reset
//   en            enable; 0 releases the current grant, blocks new ones
//   req[7:0]      level-held requests, one per channel
//   done          owner finished (only looked at while granted)
//   prio[7:0]     priority mask (only with MUX_SCHED_PRIO_EN defined)
//   a, b, c       mux select bits 0..2
//   g             mux strobe, active low
//   gnt[7:0]      one-hot grant, nonzero exactly while g = 0
//   busy          scheduler not idle
//   timeout       one-cycle pulse when HOLD_MAX ends a grant
//
// Parameters: HOLD_MAX (0 = unlimited hold), GUARD_CYC (1..15).
// Optional macro: MUX_SCHED_PRIO_EN adds the prio port.
`timescale 1ns/1ps

module mux_rr_scheduler #(
  parameter int HOLD_MAX  = 16,
  parameter int GUARD_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
`ifdef MUX_SCHED_PRIO_EN
  input  logic [7:0] prio,
`endif
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       g,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_GRANT,
    S_GUARD
  } state_t;

  localparam int HW = 16;

  state_t        r_state, w_state;
  logic [2:0]    r_ptr, w_ptr;
  logic [2:0]    r_sel, w_sel;
  logic          r_g, w_g;
  logic [7:0]    r_gnt, w_gnt;
  logic          r_busy, w_busy;
  logic          r_to, w_to;
  logic [HW-1:0] r_hold, w_hold;
  logic [3:0]    r_guard, w_guard;

  logic [7:0]    w_req_m;
  logic [2:0]    w_pick;
  logic          w_rel;

`ifdef MUX_SCHED_PRIO_EN
  logic [7:0]    w_pm;
  assign w_pm    = req & prio;
  assign w_req_m = (|w_pm) ? w_pm : req;
`else
  assign w_req_m = req;
`endif

  // Scan downwards so the nearest set bit after r_ptr wins.
  always_comb begin
    w_pick = '0;
    for (int k = 7; k >= 0; k--) begin
      if (w_req_m[r_ptr + 3'(k) + 3'd1])
        w_pick = r_ptr + 3'(k) + 3'd1;
    end
  end

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_sel   = r_sel;
    w_g     = 1'b1;
    w_gnt   = '0;
    w_to    = 1'b0;
    w_hold  = r_hold;
    w_guard = r_guard;
    w_rel   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (en && (|w_req_m)) begin
          w_sel   = w_pick;
          w_state = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!en) begin
          w_state = S_GUARD;
          w_guard = 4'(GUARD_CYC);
        end else begin
          w_state = S_GRANT;
          w_g     = 1'b0;
          w_gnt   = 8'd1 << r_sel;
          w_hold  = HW'(1);
        end
      end
      S_GRANT: begin
        if (!en || done || !req[r_sel]) begin
          w_rel = 1'b1;
        end else if ((HOLD_MAX != 0) &&
                     (r_hold == HW'(HOLD_MAX))) begin
          w_rel = 1'b1;
          w_to  = 1'b1;
        end else begin
          w_g   = 1'b0;
          w_gnt = r_gnt;
          if (r_hold != '1)
            w_hold = r_hold + HW'(1);
        end
        if (w_rel) begin
          w_ptr   = r_sel;
          w_state = S_GUARD;
          w_guard = 4'(GUARD_CYC);
          w_hold  = '0;
        end
      end
      S_GUARD: begin
        w_guard = r_guard - 4'd1;
        if (r_guard <= 4'd1)
          w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 3'd7;
      r_sel   <= '0;
      r_g     <= 1'b1;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_to    <= 1'b0;
      r_hold  <= '0;
      r_guard <= '0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_sel   <= w_sel;
      r_g     <= w_g;
      r_gnt   <= w_gnt;
      r_busy  <= w_busy;
      r_to    <= w_to;
      r_hold  <= w_hold;
      r_guard <= w_guard;
    end
  end

  assign {c, b, a} = r_sel;
  assign g         = r_g;
  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign timeout   = r_to;

endmodule
